// File: rtl/hififo_pkg.sv
// Shared definitions for the hififo pattern engine: channel modes, PIO register
// offsets and CTRL bit positions.
package hififo_pkg;

   typedef enum logic [1:0] {
      MODE_LOOP  = 2'd0,
      MODE_COUNT = 2'd1,
      MODE_LFSR  = 2'd2,
      MODE_OFF   = 2'd3
   } mode_e;

   localparam int unsigned PIO_REGS  = 4;
   localparam int unsigned PIO_CTRL  = 0;
   localparam int unsigned PIO_LEN   = 1;
   localparam int unsigned PIO_SEED  = 2;
   localparam int unsigned PIO_CLEAR = 3;

   localparam int unsigned CTRL_MODE_LSB   = 0;
   localparam int unsigned CTRL_ENABLE_BIT = 2;
   localparam int unsigned CTRL_CHECK_BIT  = 3;

   // COUNT and LFSR both produce a sequence; LOOP and OFF do not.
   function automatic logic is_gen_mode(mode_e m);
      return (m == MODE_COUNT) || (m == MODE_LFSR);
   endfunction

endpackage

// File: rtl/hififo_seq_step.sv
// One step of the selected test sequence; shared by the generator and the checker
// so both always agree on what "next word" means.
module hififo_seq_step
   import hififo_pkg::*;
#(
   parameter int unsigned WIDTH     = 64,
   parameter logic [63:0] LFSR_TAPS = 64'hD800000000000000
) (
   input  logic [WIDTH-1:0] cur_i,
   input  mode_e            mode_i,
   output logic [WIDTH-1:0] next_o
);

   localparam logic [WIDTH-1:0] TAPS = LFSR_TAPS[WIDTH-1:0];

   logic feedback;

   assign feedback = ^(cur_i & TAPS);

   always_comb begin
      next_o = cur_i;
      case (mode_i)
         MODE_COUNT: next_o = cur_i + WIDTH'(1);
         MODE_LFSR:  next_o = {cur_i[WIDTH-2:0], feedback};
         default:    next_o = cur_i;
      endcase
   end

endmodule

// File: rtl/hififo_pattern_engine.sv
// Per-channel FIFO test engine: generates COUNT/LFSR words into the TPC FIFO or loops
// FPC words back, checks FPC words against the sequence, and keeps word/error counters.
module hififo_pattern_engine
   import hififo_pkg::*;
#(
   parameter int unsigned WIDTH     = 64,
   parameter logic [12:0] PIO_BASE  = 13'd16,
   parameter logic [63:0] LFSR_TAPS = 64'hD800000000000000,
   parameter int unsigned CNT_W     = 32
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             pio_write_valid,
   input  logic [12:0]      pio_address,
   input  logic [WIDTH-1:0] pio_write_data,
   output logic [WIDTH-1:0] tpc_data,
   output logic             tpc_write,
   input  logic             tpc_ready,
   input  logic [WIDTH-1:0] fpc_data,
   input  logic             fpc_valid,
   output logic             fpc_read,
   output logic [CNT_W-1:0] tx_count,
   output logic [CNT_W-1:0] rx_count,
   output logic [CNT_W-1:0] err_count,
   output logic             done
);

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_RUN  = 1'b1;

   logic [0:0]       state_q, state_d;
   mode_e            mode_q, mode_d;
   logic             enable_q, enable_d;
   logic             check_q, check_d;
   logic [CNT_W-1:0] len_q, len_d;
   logic [WIDTH-1:0] seed_q, seed_d;
   logic [WIDTH-1:0] gen_q, gen_d;
   logic [WIDTH-1:0] exp_q, exp_d;
   logic [CNT_W-1:0] tx_q, tx_d;
   logic [CNT_W-1:0] rx_q, rx_d;
   logic [CNT_W-1:0] err_q, err_d;
   logic             done_q, done_d;
   logic [WIDTH-1:0] tpc_data_q, tpc_data_d;
   logic             tpc_write_q, tpc_write_d;
   logic             ready_q;

   logic [PIO_REGS-1:0]   pio_hit;
   logic                  wr_ctrl, wr_len, wr_seed, wr_clear;
   mode_e                 ctrl_mode;
   logic                  ctrl_enable, ctrl_check;
   logic                  rearm, reload;
   logic                  run, gen_mode, consumed, chk_mismatch;
   logic [WIDTH-1:0]      reload_val;
   logic [1:0][WIDTH-1:0] step_cur, step_nxt;

   // One decoder per owned PIO word.
   for (genvar gi = 0; gi < PIO_REGS; gi++) begin : g_pio_dec
      assign pio_hit[gi] = pio_write_valid && (pio_address == PIO_BASE + 13'(gi));
   end

   assign wr_ctrl     = pio_hit[PIO_CTRL];
   assign wr_len      = pio_hit[PIO_LEN];
   assign wr_seed     = pio_hit[PIO_SEED];
   assign wr_clear    = pio_hit[PIO_CLEAR];
   assign ctrl_mode   = mode_e'(pio_write_data[CTRL_MODE_LSB +: 2]);
   assign ctrl_enable = pio_write_data[CTRL_ENABLE_BIT];
   assign ctrl_check  = pio_write_data[CTRL_CHECK_BIT];

   assign rearm  = wr_ctrl && ctrl_enable && !enable_q;
   assign reload = wr_clear || rearm;

   assign run          = (state_q == ST_RUN);
   assign gen_mode     = is_gen_mode(mode_q);
   assign fpc_read     = run && (gen_mode || ready_q);
   assign consumed     = fpc_valid && fpc_read;
   assign chk_mismatch = (fpc_data != exp_q);

   // Index 0 advances the generator; index 1 advances the checker, resyncing
   // onto the received word whenever it did not match.
   assign step_cur[0] = gen_q;
   assign step_cur[1] = chk_mismatch ? fpc_data : exp_q;

   for (genvar gi = 0; gi < 2; gi++) begin : g_step
      hififo_seq_step #(
         .WIDTH     (WIDTH),
         .LFSR_TAPS (LFSR_TAPS)
      ) u_step (
         .cur_i  (step_cur[gi]),
         .mode_i (mode_q),
         .next_o (step_nxt[gi])
      );
   end

   always_comb begin
      mode_d      = mode_q;
      enable_d    = enable_q;
      check_d     = check_q;
      len_d       = len_q;
      seed_d      = seed_q;
      gen_d       = gen_q;
      exp_d       = exp_q;
      tx_d        = tx_q;
      rx_d        = rx_q;
      err_d       = err_q;
      done_d      = done_q;
      tpc_data_d  = tpc_data_q;
      tpc_write_d = 1'b0;
      reload_val  = seed_q;

      if (wr_ctrl) begin
         mode_d   = ctrl_mode;
         enable_d = ctrl_enable;
         check_d  = ctrl_check;
      end
      if (wr_len) begin
         len_d = pio_write_data[CNT_W-1:0];
      end
      if (wr_seed) begin
         seed_d = pio_write_data;
      end

      if (run) begin
         if (!gen_mode) begin
            if (consumed) begin
               tpc_write_d = 1'b1;
               tpc_data_d  = fpc_data;
               tx_d        = tx_q + CNT_W'(1);
            end
         end else begin
            // A reload cycle emits nothing so the restarted stream begins at SEED.
            if (tpc_ready && !reload) begin
               tpc_write_d = 1'b1;
               tpc_data_d  = gen_q;
               gen_d       = step_nxt[0];
               tx_d        = tx_q + CNT_W'(1);
               if ((len_q != '0) && (tx_d == len_q)) begin
                  done_d = 1'b1;
               end
            end
            if (consumed && check_q) begin
               if (chk_mismatch && !(&err_q)) begin
                  err_d = err_q + CNT_W'(1);
               end
               exp_d = step_nxt[1];
            end
         end
         if (consumed) begin
            rx_d = rx_q + CNT_W'(1);
         end
      end

      // An all-zero LFSR state would lock up, so a zero seed starts at 1.
      if ((mode_d == MODE_LFSR) && (seed_q == '0)) begin
         reload_val = WIDTH'(1);
      end
      if (reload) begin
         gen_d  = reload_val;
         exp_d  = reload_val;
         done_d = 1'b0;
      end
      if (wr_clear) begin
         tx_d  = '0;
         rx_d  = '0;
         err_d = '0;
      end

      state_d = (enable_d && (mode_d != MODE_OFF) && !done_d) ? ST_RUN : ST_IDLE;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= ST_IDLE;
         mode_q      <= MODE_OFF;
         enable_q    <= 1'b0;
         check_q     <= 1'b0;
         len_q       <= '0;
         seed_q      <= '0;
         gen_q       <= '0;
         exp_q       <= '0;
         tx_q        <= '0;
         rx_q        <= '0;
         err_q       <= '0;
         done_q      <= 1'b0;
         tpc_data_q  <= '0;
         tpc_write_q <= 1'b0;
         ready_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         mode_q      <= mode_d;
         enable_q    <= enable_d;
         check_q     <= check_d;
         len_q       <= len_d;
         seed_q      <= seed_d;
         gen_q       <= gen_d;
         exp_q       <= exp_d;
         tx_q        <= tx_d;
         rx_q        <= rx_d;
         err_q       <= err_d;
         done_q      <= done_d;
         tpc_data_q  <= tpc_data_d;
         tpc_write_q <= tpc_write_d;
         ready_q     <= tpc_ready;
      end
   end

   assign tpc_data  = tpc_data_q;
   assign tpc_write = tpc_write_q;
   assign tx_count  = tx_q;
   assign rx_count  = rx_q;
   assign err_count = err_q;
   assign done      = done_q;

endmodule

// File: tb/tb_hififo_pattern_engine.sv
// Bench for hififo_pattern_engine: directed scenarios plus random traffic, all checked
// every cycle against a behavioural model of the engine.
module tb_hififo_pattern_engine;

   localparam int          WIDTH = 64;
   localparam int          CNT_W = 8;
   localparam int          CMOD  = 1 << CNT_W;
   localparam logic [12:0] BASE  = 13'd16;
   localparam logic [63:0] TAPS  = 64'hD800000000000000;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic        pio_write_valid = 1'b0;
   logic [12:0] pio_address = '0;
   logic [63:0] pio_write_data = '0;
   logic [63:0] tpc_data;
   logic        tpc_write;
   logic        tpc_ready = 1'b1;
   logic [63:0] fpc_data = '0;
   logic        fpc_valid = 1'b0;
   logic        fpc_read;
   logic [CNT_W-1:0] tx_count, rx_count, err_count;
   logic        done;

   int tests = 0;
   int fails = 0;

   hififo_pattern_engine #(
      .WIDTH     (WIDTH),
      .PIO_BASE  (BASE),
      .LFSR_TAPS (TAPS),
      .CNT_W     (CNT_W)
   ) dut (
      .clock           (clock),
      .reset_n         (reset_n),
      .pio_write_valid (pio_write_valid),
      .pio_address     (pio_address),
      .pio_write_data  (pio_write_data),
      .tpc_data        (tpc_data),
      .tpc_write       (tpc_write),
      .tpc_ready       (tpc_ready),
      .fpc_data        (fpc_data),
      .fpc_valid       (fpc_valid),
      .fpc_read        (fpc_read),
      .tx_count        (tx_count),
      .rx_count        (rx_count),
      .err_count       (err_count),
      .done            (done)
   );

   initial forever #5 clock = ~clock;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got %h, required %h (t=%0t)", name, act, req, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   int          m_mode, m_len, m_tx, m_rx, m_err;
   bit          m_en, m_chk, m_done, m_twrite, m_rdy;
   logic [63:0] m_seed, m_gen, m_exp, m_tdata;

   function automatic logic [63:0] seq_next(input int mode, input logic [63:0] c);
      logic [63:0] t;
      logic        p;
      t = TAPS;
      p = 1'b0;
      if (mode == 1) return c + 64'd1;
      if (mode == 2) begin
         for (int i = 0; i < 64; i++) if (t[i]) p = p ^ c[i];
         return {c[62:0], p};
      end
      return c;
   endfunction

   function automatic bit m_run();
      return m_en && (m_mode != 3) && !m_done;
   endfunction

   function automatic bit m_fpc_read();
      return m_run() && (m_mode != 0 || m_rdy);
   endfunction

   task automatic model_reset();
      m_mode = 3; m_en = 0; m_chk = 0; m_len = 0; m_seed = '0;
      m_gen = '0; m_exp = '0; m_tx = 0; m_rx = 0; m_err = 0;
      m_done = 0; m_tdata = '0; m_twrite = 0; m_rdy = 0;
   endtask

   task automatic model_step();
      bit          run, consumed, clr, rearm;
      int          off;
      logic [63:0] start;
      run      = m_run();
      consumed = fpc_valid && m_fpc_read();
      off      = int'(pio_address) - int'(BASE);
      clr      = pio_write_valid && (off == 3);
      rearm    = pio_write_valid && (off == 0) && pio_write_data[2] && !m_en;
      m_twrite = 0;
      if (run) begin
         if (m_mode == 0) begin
            if (consumed) begin
               m_twrite = 1;
               m_tdata  = fpc_data;
               m_tx     = (m_tx + 1) % CMOD;
            end
         end else begin
            if (tpc_ready && !clr && !rearm) begin
               m_twrite = 1;
               m_tdata  = m_gen;
               m_gen    = seq_next(m_mode, m_gen);
               m_tx     = (m_tx + 1) % CMOD;
               if (m_len != 0 && m_tx == m_len) m_done = 1;
            end
            if (consumed && m_chk) begin
               if (fpc_data !== m_exp) begin
                  if (m_err < CMOD - 1) m_err++;
                  m_exp = seq_next(m_mode, fpc_data);
               end else begin
                  m_exp = seq_next(m_mode, m_exp);
               end
            end
         end
         if (consumed) m_rx = (m_rx + 1) % CMOD;
      end
      m_rdy = tpc_ready;
      if (pio_write_valid && off == 0) begin
         m_mode = int'(pio_write_data[1:0]);
         m_en   = pio_write_data[2];
         m_chk  = pio_write_data[3];
      end
      if (pio_write_valid && off == 1) m_len = int'(pio_write_data[CNT_W-1:0]);
      if (pio_write_valid && off == 2) m_seed = pio_write_data;
      if (clr || rearm) begin
         start  = (m_mode == 2 && m_seed == 0) ? 64'd1 : m_seed;
         m_gen  = start;
         m_exp  = start;
         m_done = 0;
      end
      if (clr) begin
         m_tx = 0; m_rx = 0; m_err = 0;
      end
   endtask

   initial begin
      model_reset();
      forever begin
         @(posedge clock or negedge reset_n);
         if (!reset_n) model_reset();
         else model_step();
      end
   end

   // Every-cycle compare of all outputs against the model, plus stream capture.
   logic [63:0] cap[$];
   initial forever begin
      @(negedge clock);
      chk("tpc_write", 64'(tpc_write), 64'(m_twrite));
      if (m_twrite) chk("tpc_data", tpc_data, m_tdata);
      chk("fpc_read", 64'(fpc_read), 64'(m_fpc_read()));
      chk("tx_count", 64'(tx_count), 64'(m_tx));
      chk("rx_count", 64'(rx_count), 64'(m_rx));
      chk("err_count", 64'(err_count), 64'(m_err));
      chk("done", 64'(done), 64'(m_done));
      if (tpc_write === 1'b1) cap.push_back(tpc_data);
   end

   // ---------------- stimulus helpers ----------------
   task automatic pio_wr(input int off, input logic [63:0] d);
      pio_write_valid = 1'b1;
      pio_address     = BASE + 13'(off);
      pio_write_data  = d;
      @(negedge clock);
      pio_write_valid = 1'b0;
   endtask

   task automatic ctrl(input logic [1:0] mode, input logic en, input logic ck);
      pio_wr(0, {60'd0, ck, en, mode});
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clock);
   endtask

   task automatic feed(input logic [63:0] d);
      int n;
      n = 0;
      fpc_data  = d;
      fpc_valid = 1'b1;
      while (fpc_read !== 1'b1 && n < 50) begin
         @(negedge clock);
         n++;
      end
      if (n >= 50) chk("feed_timeout", 64'(n), 64'd0);
      @(negedge clock);
      fpc_valid = 1'b0;
   endtask

   initial begin
      #1_000_000;
      fails++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   // ---------------- scenarios ----------------
   initial begin
      int          start;
      logic [63:0] w, e;
      logic [63:0] aa[3];

      chk("model_lfsr_msb", seq_next(2, 64'h8000000000000000), 64'h1);
      chk("model_lfsr_tap60", seq_next(2, 64'h1000000000000000), 64'h2000000000000001);

      idle(3);
      chk("rst_tpc_write", 64'(tpc_write), 64'd0);
      chk("rst_tpc_data", tpc_data, 64'd0);
      chk("rst_fpc_read", 64'(fpc_read), 64'd0);
      chk("rst_tx", 64'(tx_count), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      reset_n = 1'b1;
      idle(2);

      // COUNT burst of 4 from seed 5
      pio_wr(3, 0); pio_wr(2, 5); pio_wr(1, 4);
      start = cap.size();
      ctrl(2'd1, 1'b1, 1'b0);
      idle(8);
      chk("count_words", 64'(cap.size() - start), 64'd4);
      for (int i = 0; i < 4 && start + i < cap.size(); i++)
         chk("count_word", cap[start + i], 64'(5 + i));
      chk("count_done", 64'(done), 64'd1);
      chk("count_tx", 64'(tx_count), 64'd4);
      chk("count_tpc_write", 64'(tpc_write), 64'd0);

      // backpressure: unbounded COUNT from 100, tpc_ready toggled every 3 cycles
      ctrl(2'd3, 1'b0, 1'b0);
      pio_wr(3, 0); pio_wr(2, 100); pio_wr(1, 0);
      idle(2);
      start = cap.size();
      ctrl(2'd1, 1'b1, 1'b0);
      for (int i = 0; i < 30; i++) begin
         tpc_ready = ((i / 3) % 2) == 0;
         @(negedge clock);
      end
      ctrl(2'd3, 1'b0, 1'b0);
      tpc_ready = 1'b1;
      idle(3);
      chk("bp_enough_words", 64'(cap.size() - start >= 10), 64'd1);
      for (int i = start; i < cap.size(); i++)
         chk("bp_seq", cap[i], 64'(100 + i - start));

      // LOOP with gaps
      pio_wr(3, 0);
      aa[0] = 64'hA0A0_0000_0000_000A;
      aa[1] = 64'hB0B0_0000_0000_000B;
      aa[2] = 64'hC0C0_0000_0000_000C;
      start = cap.size();
      ctrl(2'd0, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) begin
         idle(int'($urandom_range(1, 3)));
         feed(aa[i]);
      end
      idle(3);
      chk("loop_words", 64'(cap.size() - start), 64'd3);
      for (int i = 0; i < 3 && start + i < cap.size(); i++)
         chk("loop_word", cap[start + i], aa[i]);
      chk("loop_rx", 64'(rx_count), 64'd3);
      chk("loop_tx", 64'(tx_count), 64'd3);

      // LFSR checker, word 4 corrupted and the stream continues from it
      ctrl(2'd3, 1'b0, 1'b0);
      pio_wr(3, 0); pio_wr(2, 1);
      ctrl(2'd2, 1'b1, 1'b1);
      e = 64'd1;
      for (int i = 0; i < 10; i++) begin
         w = (i == 3) ? (e ^ 64'h00F0_0000_0000_0F00) : e;
         feed(w);
         e = seq_next(2, w);
      end
      idle(2);
      chk("lfsr_err", 64'(err_count), 64'd1);
      chk("lfsr_rx", 64'(rx_count), 64'd10);

      // LFSR zero seed starts at 1
      ctrl(2'd3, 1'b0, 1'b0);
      pio_wr(3, 0); pio_wr(2, 0); pio_wr(1, 3);
      idle(2);
      start = cap.size();
      ctrl(2'd2, 1'b1, 1'b0);
      idle(6);
      chk("lfsr0_words", 64'(cap.size() - start), 64'd3);
      if (cap.size() - start >= 3) begin
         chk("lfsr0_w0", cap[start], 64'd1);
         chk("lfsr0_w1", cap[start + 1], 64'd2);
         chk("lfsr0_w2", cap[start + 2], 64'd4);
      end

      // error saturation and rx wrap: 300 garbage words
      ctrl(2'd3, 1'b0, 1'b0);
      pio_wr(1, 0); pio_wr(3, 0);
      ctrl(2'd1, 1'b1, 1'b1);
      for (int i = 0; i < 300; i++) begin
         fpc_valid = 1'b1;
         fpc_data  = {$urandom, $urandom} | 64'h1_0000_0000;
         @(negedge clock);
      end
      fpc_valid = 1'b0;
      idle(2);
      chk("sat_err", 64'(err_count), 64'(CMOD - 1));
      chk("wrap_rx", 64'(rx_count), 64'(300 % CMOD));

      // async reset mid-burst
      ctrl(2'd3, 1'b0, 1'b0);
      pio_wr(3, 0); pio_wr(2, 7);
      ctrl(2'd1, 1'b1, 1'b0);
      idle(5);
      chk("pre_reset_running", 64'(tpc_write), 64'd1);
      @(posedge clock);
      #2 reset_n = 1'b0;
      #1;
      chk("arst_tpc_write", 64'(tpc_write), 64'd0);
      chk("arst_tpc_data", tpc_data, 64'd0);
      chk("arst_tx", 64'(tx_count), 64'd0);
      chk("arst_fpc_read", 64'(fpc_read), 64'd0);
      chk("arst_err", 64'(err_count), 64'd0);
      @(negedge clock);
      reset_n = 1'b1;
      idle(1);

      // CLEAR colliding with a consumed word
      ctrl(2'd1, 1'b1, 1'b1);
      feed(64'd0);
      chk("coll_rx_before", 64'(rx_count), 64'd1);
      fpc_valid       = 1'b1;
      fpc_data        = 64'd1;
      pio_write_valid = 1'b1;
      pio_address     = BASE + 13'd3;
      pio_write_data  = '0;
      @(negedge clock);
      pio_write_valid = 1'b0;
      fpc_valid       = 1'b0;
      chk("coll_rx_after", 64'(rx_count), 64'd0);
      feed(64'd0);
      chk("coll_rx_next", 64'(rx_count), 64'd1);
      chk("coll_err_next", 64'(err_count), 64'd0);

      // random traffic against the model
      for (int i = 0; i < 2000; i++) begin
         int off;
         tpc_ready = ($urandom % 4) != 0;
         fpc_valid = $urandom % 2;
         fpc_data  = ($urandom % 2) ? m_exp : {$urandom, $urandom};
         if ($urandom % 12 == 0) begin
            off = int'($urandom % 5);
            pio_write_valid = 1'b1;
            pio_address     = BASE + 13'(off);
            case (off)
               0:       pio_write_data = 64'($urandom % 16);
               1:       pio_write_data = 64'($urandom % 6);
               2:       pio_write_data = ($urandom % 3 == 0) ? 64'd0 : {$urandom, $urandom};
               default: pio_write_data = {$urandom, $urandom};
            endcase
         end else begin
            pio_write_valid = 1'b0;
         end
         @(negedge clock);
      end
      pio_write_valid = 1'b0;
      fpc_valid       = 1'b0;
      idle(3);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
